// File: rtl/io_deserializer.sv
// io_deserializer
// Serial-to-parallel converter with word alignment.  Bits arrive MSB first on D
// and are sampled on rising CLK edges where EN is high.  After every WIDTH
// sampled bits the assembled word is presented on Q, and DATA_VALID pulses for
// one cycle.  The word boundary can be moved one bit later by a "slip".
//   MANUAL mode: each rising edge of BITSLIP requests one slip.  LOCKED rises
//                after the first word and then stays high.
//   AUTO mode:   an internal HUNT/SLIP/LOCKED machine compares each word with
//                TRAIN_PATTERN[WIDTH-1:0].  It slips after every mismatch and
//                locks after LOCK_COUNT consecutive matches.  While locked, a
//                BITSLIP rising edge forces a retrain.
//
// Ports
//   CLK        in   serial bit clock (rising edge only)
//   RST        in   asynchronous active-high reset
//   D          in   serial data, MSB first
//   EN         in   sample enable
//   BITSLIP    in   slip request (MANUAL) / retrain request (AUTO), edge-detected
//   Q          out  parallel word, WIDTH bits
//   DATA_VALID out  one-cycle strobe marking a new Q
//   LOCKED     out  word alignment achieved
//   ALIGN_ERR  out  sticky flag: alignment not found after 2*WIDTH misses

module io_deserializer #(
   parameter int          WIDTH         = 4,
   parameter string       BITSLIP_MODE  = "MANUAL",
   parameter logic [9:0]  TRAIN_PATTERN = 10'h0A5,
   parameter int          LOCK_COUNT    = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             D,
   input  logic             EN,
   input  logic             BITSLIP,
   output logic [WIDTH-1:0] Q,
   output logic             DATA_VALID,
   output logic             LOCKED,
   output logic             ALIGN_ERR
);

   // Reject illegal parameter values at elaboration time.
   if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
      $error("io_deserializer: WIDTH must be in 3..10");
   end
   if (BITSLIP_MODE != "MANUAL" && BITSLIP_MODE != "AUTO") begin : g_bad_mode
      $error("io_deserializer: BITSLIP_MODE must be \"MANUAL\" or \"AUTO\"");
   end
   if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock
      $error("io_deserializer: LOCK_COUNT must be in 1..15");
   end

   localparam bit                 AUTO_MODE  = (BITSLIP_MODE == "AUTO");
   localparam int                 CW         = $clog2(WIDTH);
   localparam logic [CW-1:0]      CNT_MAX    = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0]   PATTERN    = TRAIN_PATTERN[WIDTH-1:0];
   localparam logic [3:0]         LOCK_VAL   = 4'(LOCK_COUNT);
   localparam logic [4:0]         ERR_THRESH = 5'(2 * WIDTH);
   localparam logic [4:0]         MISS_MAX   = 5'd31;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SLIP   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             dv_q, dv_d;
   logic             slip_pend_q, slip_pend_d;
   logic             bs_prev_q, bs_prev_d;
   logic [3:0]       match_cnt_q, match_cnt_d;
   logic [4:0]       miss_cnt_q, miss_cnt_d;
   logic             locked_q, locked_d;
   logic             align_err_q, align_err_d;
   state_t           state_q, state_d;

   logic             bs_rise;
   logic             word_done;
   logic             slip_req;
   logic [WIDTH-1:0] word_next;

   // Next-state logic.  The datapath (shift register, bit counter, output word)
   // is evaluated first so the alignment logic can see whether this edge
   // completes a word; slip requests from either mode are merged at the end.
   always_comb begin
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      q_d         = q_q;
      dv_d        = 1'b0;
      slip_pend_d = slip_pend_q;
      bs_prev_d   = BITSLIP;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      locked_d    = locked_q;
      align_err_d = align_err_q;
      state_d     = state_q;
      word_done   = 1'b0;
      slip_req    = 1'b0;
      bs_rise     = BITSLIP & ~bs_prev_q;
      word_next   = {sr_q[WIDTH-2:0], D};

      // A consumed slip keeps the counter still for one sampled bit, which
      // pushes the word boundary one bit later.
      if (EN) begin
         sr_d = word_next;
         if (slip_pend_q) begin
            cnt_d = cnt_q;
         end else if (cnt_q == CNT_MAX) begin
            cnt_d     = '0;
            q_d       = word_next;
            dv_d      = 1'b1;
            word_done = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (!AUTO_MODE) begin
         slip_req = bs_rise;
         if (word_done) begin
            locked_d = 1'b1;
         end
      end else if (EN) begin
         case (state_q)
            ST_HUNT: begin
               if (word_done) begin
                  if (word_next == PATTERN) begin
                     match_cnt_d = match_cnt_q + 4'd1;
                     if (match_cnt_d == LOCK_VAL) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                     end
                  end else begin
                     match_cnt_d = '0;
                     miss_cnt_d  = (miss_cnt_q == MISS_MAX) ? MISS_MAX : miss_cnt_q + 5'd1;
                     state_d     = ST_SLIP;
                     slip_req    = 1'b1;
                     if (miss_cnt_d >= ERR_THRESH) begin
                        align_err_d = 1'b1;
                     end
                  end
               end
            end
            ST_SLIP: begin
               if (slip_pend_q) begin
                  state_d = ST_HUNT;
               end
            end
            ST_LOCKED: begin
               if (bs_rise) begin
                  locked_d    = 1'b0;
                  match_cnt_d = '0;
                  miss_cnt_d  = '0;
                  align_err_d = 1'b0;
                  state_d     = ST_HUNT;
               end
            end
            default: begin
               state_d = ST_HUNT;
            end
         endcase
      end

      // Only one slip may be outstanding; requests seen while one is pending
      // (including on the edge that consumes it) are dropped.
      if (slip_pend_q) begin
         if (EN) begin
            slip_pend_d = 1'b0;
         end
      end else if (slip_req) begin
         slip_pend_d = 1'b1;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sr_q        <= '0;
         cnt_q       <= '0;
         q_q         <= '0;
         dv_q        <= 1'b0;
         slip_pend_q <= 1'b0;
         bs_prev_q   <= 1'b0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         locked_q    <= 1'b0;
         align_err_q <= 1'b0;
         state_q     <= ST_HUNT;
      end else begin
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         q_q         <= q_d;
         dv_q        <= dv_d;
         slip_pend_q <= slip_pend_d;
         bs_prev_q   <= bs_prev_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         locked_q    <= locked_d;
         align_err_q <= align_err_d;
         state_q     <= state_d;
      end
   end

   assign Q          = q_q;
   assign DATA_VALID = dv_q;
   assign LOCKED     = locked_q;
   assign ALIGN_ERR  = align_err_q;

endmodule

// File: tb/tb_io_deserializer.sv
// tb_io_deserializer
// Self-checking bench for io_deserializer.  Two instances share clock and
// reset: dut_m (WIDTH=4, MANUAL) and dut_a (WIDTH=4, AUTO, pattern 4'b0101).
// Each test pushes the words it expects onto a scoreboard queue as it drives
// the stimulus, and pops/compares whenever DATA_VALID is seen.

module tb_io_deserializer;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;

   logic       m_d = 1'b0, m_en = 1'b0, m_bs = 1'b0;
   logic [3:0] m_q;
   logic       m_dv, m_locked, m_aerr;

   logic       a_d = 1'b0, a_en = 1'b0, a_bs = 1'b0;
   logic [3:0] a_q;
   logic       a_dv, a_locked, a_aerr;

   int         checks = 0;
   int         errors = 0;
   logic [3:0] exp_q[$];
   logic [3:0] exp_w;

   always #5 CLK = ~CLK;

   io_deserializer #(
      .WIDTH(4), .BITSLIP_MODE("MANUAL"), .TRAIN_PATTERN(10'h0A5), .LOCK_COUNT(4)
   ) dut_m (
      .CLK(CLK), .RST(RST), .D(m_d), .EN(m_en), .BITSLIP(m_bs),
      .Q(m_q), .DATA_VALID(m_dv), .LOCKED(m_locked), .ALIGN_ERR(m_aerr)
   );

   io_deserializer #(
      .WIDTH(4), .BITSLIP_MODE("AUTO"), .TRAIN_PATTERN(10'h0A5), .LOCK_COUNT(4)
   ) dut_a (
      .CLK(CLK), .RST(RST), .D(a_d), .EN(a_en), .BITSLIP(a_bs),
      .Q(a_q), .DATA_VALID(a_dv), .LOCKED(a_locked), .ALIGN_ERR(a_aerr)
   );

   // Drive one bit into the MANUAL instance and sample just after the edge.
   task automatic step_m(input logic d, input logic en, input logic bs);
      @(negedge CLK);
      m_d = d; m_en = en; m_bs = bs;
      @(posedge CLK);
      #1;
   endtask

   // Drive one bit into the AUTO instance and sample just after the edge.
   task automatic step_a(input logic d, input logic en, input logic bs);
      @(negedge CLK);
      a_d = d; a_en = en; a_bs = bs;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      m_en = 1'b0; m_bs = 1'b0; m_d = 1'b0;
      a_en = 1'b0; a_bs = 1'b0; a_d = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      #2 RST = 1'b1;
      #1;
      checks++;
      if (m_q !== 4'b0000 || m_dv !== 1'b0 || m_locked !== 1'b0 || m_aerr !== 1'b0) begin
         errors++;
         $display("FAIL reset_manual: Q=%b DV=%b LOCKED=%b AERR=%b, expected all 0", m_q, m_dv, m_locked, m_aerr);
      end
      checks++;
      if (a_q !== 4'b0000 || a_dv !== 1'b0 || a_locked !== 1'b0 || a_aerr !== 1'b0) begin
         errors++;
         $display("FAIL reset_auto: Q=%b DV=%b LOCKED=%b AERR=%b, expected all 0", a_q, a_dv, a_locked, a_aerr);
      end
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_basic_word();
      logic [3:0] bits;
      bits = 4'b1011;
      do_reset();
      exp_q.push_back(4'b1011);
      for (int i = 3; i >= 0; i--) begin
         step_m(bits[i], 1'b1, 1'b0);
         checks++;
         if (m_dv !== (i == 0)) begin
            errors++;
            $display("FAIL basic_dv: bit %0d DV=%b expected %b", 3 - i, m_dv, (i == 0));
         end
         checks++;
         if (m_locked !== (i == 0)) begin
            errors++;
            $display("FAIL basic_locked: bit %0d LOCKED=%b expected %b", 3 - i, m_locked, (i == 0));
         end
         if (m_dv) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL basic_word: unexpected DATA_VALID Q=%b", m_q);
            end else begin
               exp_w = exp_q.pop_front();
               if (m_q !== exp_w) begin
                  errors++;
                  $display("FAIL basic_word: Q=%b expected %b", m_q, exp_w);
               end
            end
         end
      end
      step_m(1'b0, 1'b1, 1'b0);
      checks++;
      if (m_dv !== 1'b0 || m_locked !== 1'b1 || m_aerr !== 1'b0 || m_q !== 4'b1011) begin
         errors++;
         $display("FAIL basic_after: DV=%b LOCKED=%b AERR=%b Q=%b expected 0 1 0 1011", m_dv, m_locked, m_aerr, m_q);
      end
   endtask

   // Stream 1100 repeated; a slip before word 2 and one on a completion edge.
   task automatic test_bitslip();
      logic b, bs;
      int   nvalid;
      nvalid = 0;
      do_reset();
      exp_q.push_back(4'b1100);
      exp_q.push_back(4'b1001);
      exp_q.push_back(4'b1001);
      exp_q.push_back(4'b1001);
      exp_q.push_back(4'b1001);
      exp_q.push_back(4'b0011);
      for (int n = 1; n <= 26; n++) begin
         b  = (n % 4 == 1) || (n % 4 == 2);
         bs = (n == 5) || (n == 6) || (n == 21);
         step_m(b, 1'b1, bs);
         if (m_dv) begin
            nvalid++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL bitslip_word: edge %0d unexpected DATA_VALID Q=%b", n, m_q);
            end else begin
               exp_w = exp_q.pop_front();
               if (m_q !== exp_w) begin
                  errors++;
                  $display("FAIL bitslip_word: edge %0d Q=%b expected %b", n, m_q, exp_w);
               end
            end
         end
      end
      checks++;
      if (nvalid != 6 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bitslip_count: saw %0d words expected 6", nvalid);
      end
   endtask

   task automatic test_en_stall();
      logic [3:0] w1, w2;
      w1 = 4'b0110;
      w2 = 4'b1011;
      do_reset();
      for (int i = 3; i >= 0; i--) step_m(w1[i], 1'b1, 1'b0);
      checks++;
      if (m_dv !== 1'b1 || m_q !== w1) begin
         errors++;
         $display("FAIL stall_first: DV=%b Q=%b expected 1 %b", m_dv, m_q, w1);
      end
      step_m(w2[3], 1'b1, 1'b0);
      step_m(w2[2], 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step_m(1'b1, 1'b0, 1'b0);
         checks++;
         if (m_dv !== 1'b0 || m_q !== w1) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d DV=%b Q=%b expected 0 %b", k, m_dv, m_q, w1);
         end
      end
      step_m(w2[1], 1'b1, 1'b0);
      checks++;
      if (m_dv !== 1'b0) begin
         errors++;
         $display("FAIL stall_early: DV=%b expected 0 after 3rd enabled bit", m_dv);
      end
      step_m(w2[0], 1'b1, 1'b0);
      checks++;
      if (m_dv !== 1'b1 || m_q !== w2) begin
         errors++;
         $display("FAIL stall_word: DV=%b Q=%b expected 1 %b", m_dv, m_q, w2);
      end
      step_m(1'b0, 1'b0, 1'b0);
      checks++;
      if (m_dv !== 1'b0 || m_q !== w2) begin
         errors++;
         $display("FAIL stall_dv_len: DV=%b Q=%b expected 0 %b", m_dv, m_q, w2);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] w;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         w = 4'($urandom_range(0, 15));
         exp_q.push_back(w);
         for (int i = 3; i >= 0; i--) begin
            step_m(w[i], 1'b1, 1'b0);
            if (m_dv) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL b2b_word: unexpected DATA_VALID Q=%b", m_q);
               end else begin
                  exp_w = exp_q.pop_front();
                  if (m_q !== exp_w) begin
                     errors++;
                     $display("FAIL b2b_word: word %0d Q=%b expected %b", k, m_q, exp_w);
                  end
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_missing: %0d words not produced, expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset_midword();
      logic [3:0] w1, w2;
      w1 = 4'b1110;
      w2 = 4'b1001;
      do_reset();
      for (int i = 3; i >= 0; i--) step_m(w1[i], 1'b1, 1'b0);
      step_m(1'b1, 1'b1, 1'b0);
      step_m(1'b1, 1'b1, 1'b0);
      @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      checks++;
      if (m_q !== 4'b0000 || m_locked !== 1'b0 || m_dv !== 1'b0 || m_aerr !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: Q=%b LOCKED=%b DV=%b AERR=%b expected all 0", m_q, m_locked, m_dv, m_aerr);
      end
      m_d = 1'b1; m_en = 1'b1;
      @(posedge CLK);
      #1;
      checks++;
      if (m_q !== 4'b0000 || m_locked !== 1'b0 || m_dv !== 1'b0) begin
         errors++;
         $display("FAIL rst_hold: Q=%b LOCKED=%b DV=%b expected all 0", m_q, m_locked, m_dv);
      end
      @(negedge CLK);
      RST = 1'b0;
      m_en = 1'b0;
      exp_q.delete();
      exp_q.push_back(w2);
      for (int i = 3; i >= 0; i--) begin
         step_m(w2[i], 1'b1, 1'b0);
         checks++;
         if (m_dv !== (i == 0)) begin
            errors++;
            $display("FAIL rst_first_dv: bit %0d DV=%b expected %b", 3 - i, m_dv, (i == 0));
         end
         if (m_dv) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rst_first_word: unexpected DATA_VALID Q=%b", m_q);
            end else begin
               exp_w = exp_q.pop_front();
               if (m_q !== exp_w) begin
                  errors++;
                  $display("FAIL rst_first_word: Q=%b expected %b", m_q, exp_w);
               end
            end
         end
      end
   endtask

   // Stream 1010 repeated against pattern 0101: one slip, lock at edge 21,
   // retrain at edge 25, relock at edge 41.
   task automatic test_auto_lock();
      logic b, bs, exp_lock;
      do_reset();
      exp_q.push_back(4'b1010);
      for (int k = 0; k < 9; k++) exp_q.push_back(4'b0101);
      for (int n = 1; n <= 41; n++) begin
         b  = (n % 2 == 1);
         bs = (n == 25);
         step_a(b, 1'b1, bs);
         exp_lock = (n >= 21 && n < 25) || (n >= 41);
         if (n == 20 || n == 21 || n == 25 || n == 40 || n == 41) begin
            checks++;
            if (a_locked !== exp_lock) begin
               errors++;
               $display("FAIL auto_locked: edge %0d LOCKED=%b expected %b", n, a_locked, exp_lock);
            end
         end
         if (a_dv) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL auto_word: edge %0d unexpected DATA_VALID Q=%b", n, a_q);
            end else begin
               exp_w = exp_q.pop_front();
               if (a_q !== exp_w) begin
                  errors++;
                  $display("FAIL auto_word: edge %0d Q=%b expected %b", n, a_q, exp_w);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0 || a_aerr !== 1'b0) begin
         errors++;
         $display("FAIL auto_end: %0d words left, AERR=%b, expected 0 and 0", exp_q.size(), a_aerr);
      end
   endtask

   // Constant zero never matches: words every 5 edges, ALIGN_ERR at the 8th.
   task automatic test_align_err();
      do_reset();
      for (int k = 0; k < 9; k++) exp_q.push_back(4'b0000);
      for (int n = 1; n <= 45; n++) begin
         step_a(1'b0, 1'b1, 1'b0);
         if (n == 34 || n == 39 || n == 45) begin
            checks++;
            if (a_aerr !== (n >= 39)) begin
               errors++;
               $display("FAIL align_err: edge %0d AERR=%b expected %b", n, a_aerr, (n >= 39));
            end
         end
         if (a_dv) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL align_word: edge %0d unexpected DATA_VALID Q=%b", n, a_q);
            end else begin
               exp_w = exp_q.pop_front();
               if (a_q !== exp_w) begin
                  errors++;
                  $display("FAIL align_word: edge %0d Q=%b expected %b", n, a_q, exp_w);
               end
            end
         end
      end
      checks++;
      if (a_locked !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL align_end: LOCKED=%b words left %0d, expected 0 and 0", a_locked, exp_q.size());
      end
   endtask

   initial begin
      $display("[TB] io_deserializer bench starting");
      test_reset();
      test_basic_word();
      test_bitslip();
      test_en_stall();
      test_back_to_back();
      test_reset_midword();
      test_auto_lock();
      test_align_err();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
